seg7_mux_driver: RTL

- Chip-side encoder for the two-digit multiplexed seven-segment PMOD.
- Converts a latched 8-bit value into active-low segment patterns and time-multiplexes the low and high nibble digits on one shared segment bus plus a digit-select line.
- Inserts blanking between digit switches to suppress ghosting.
- Applies new values only at frame boundaries, so the off-chip segment-to-hex decoder never sees a torn frame.

---
 rtl/seg7_mux_driver_if.sv | 20 ++
 rtl/seg7_mux_driver.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_mux_driver_if.sv
// Value handshake bundle for seg7_mux_driver.
// The master offers value_in/value_valid; the slave (the display driver)
// answers with value_ready while its pending register is empty.
interface seg7_mux_driver_if;
   logic [7:0] value_in;
   logic       value_valid;
   logic       value_ready;

   modport master (
      output value_in,
      output value_valid,
      input  value_ready
   );

   modport slave (
      input  value_in,
      input  value_valid,
      output value_ready
   );
endinterface

// File: rtl/seg7_mux_driver.sv
// Two-digit multiplexed seven-segment driver.
// Time-multiplexes the low and high nibble of a latched byte onto one
// active-low segment bus with a digit-select line, blanking all segments
// around every digit switch. New values are staged in a one-entry pending
// register and committed only on entry to SHOW_LO, so both digits of a
// frame always come from the same byte.
// Optional build macro: LEADING_ZERO_BLANK_EN -- when defined, a zero high
// nibble leaves the high digit dark instead of drawing "0".
module seg7_mux_driver #(
   parameter int REFRESH_DIV  = 6000,
   parameter int BLANK_CYCLES = 64
) (
   input  logic                      clock,
   input  logic                      reset,
   seg7_mux_driver_if.slave          val_bus,
   input  logic                      blank_in,
   output logic [6:0]                segments_n,
   output logic                      segsel,
   output logic                      frame_done
);

   localparam int MAX_DUR = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
   localparam int CNT_W   = (MAX_DUR > 2) ? $clog2(MAX_DUR) : 1;

   localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

   localparam logic [6:0] SEG_OFF = 7'h7F;

   typedef enum logic [1:0] {
      SHOW_LO     = 2'd0,
      BLANK_TO_HI = 2'd1,
      SHOW_HI     = 2'd2,
      BLANK_TO_LO = 2'd3
   } state_t;

   // Active-high segment pattern for one hex digit (bit0=a .. bit6=g).
   function automatic logic [6:0] enc7(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'h3F;
         4'h1:    seg = 7'h06;
         4'h2:    seg = 7'h5B;
         4'h3:    seg = 7'h4F;
         4'h4:    seg = 7'h66;
         4'h5:    seg = 7'h6D;
         4'h6:    seg = 7'h7D;
         4'h7:    seg = 7'h07;
         4'h8:    seg = 7'h7F;
         4'h9:    seg = 7'h6F;
         4'hA:    seg = 7'h77;
         4'hB:    seg = 7'h7C;
         4'hC:    seg = 7'h39;
         4'hD:    seg = 7'h5E;
         4'hE:    seg = 7'h79;
         4'hF:    seg = 7'h71;
         default: seg = 7'h00;
      endcase
      return seg;
   endfunction

   state_t           state_r;
   state_t           state_nx_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nx_s;
   logic             last_s;

   logic [7:0]       pend_r;
   logic [7:0]       disp_r;
   logic [7:0]       disp_nx_s;
   logic             value_ready_r;
   logic             hs_s;
   logic             commit_s;

   logic [6:0]       segments_n_r;
   logic [6:0]       seg_nx_s;
   logic             segsel_r;
   logic             frame_done_r;

   // Next-state and cycle counter: each state lasts its duration, then advances cyclically.
   always_comb begin
      state_nx_s = state_r;
      last_s     = 1'b0;
      cnt_nx_s   = cnt_r + CNT_W'(1);
      case (state_r)
         SHOW_LO: begin
            last_s = (cnt_r == SHOW_LAST);
            if (last_s) state_nx_s = BLANK_TO_HI;
            else        state_nx_s = SHOW_LO;
         end
         BLANK_TO_HI: begin
            last_s = (cnt_r == BLANK_LAST);
            if (last_s) state_nx_s = SHOW_HI;
            else        state_nx_s = BLANK_TO_HI;
         end
         SHOW_HI: begin
            last_s = (cnt_r == SHOW_LAST);
            if (last_s) state_nx_s = BLANK_TO_LO;
            else        state_nx_s = SHOW_HI;
         end
         BLANK_TO_LO: begin
            last_s = (cnt_r == BLANK_LAST);
            if (last_s) state_nx_s = SHOW_LO;
            else        state_nx_s = BLANK_TO_LO;
         end
         default: begin
            last_s     = 1'b1;
            state_nx_s = BLANK_TO_LO;
         end
      endcase
      if (last_s) cnt_nx_s = '0;
      else        cnt_nx_s = cnt_r + CNT_W'(1);
   end

   // State and counter registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= BLANK_TO_LO;
         cnt_r   <= '0;
      end else begin
         state_r <= state_nx_s;
         cnt_r   <= cnt_nx_s;
      end
   end

   // Handshake and frame-boundary commit; value_ready low means pending is full,
   // so a commit and a capture can never fall on the same edge.
   always_comb begin
      hs_s      = val_bus.value_valid && value_ready_r;
      commit_s  = last_s && (state_r == BLANK_TO_LO) && !value_ready_r;
      disp_nx_s = disp_r;
      if (commit_s) disp_nx_s = pend_r;
      else          disp_nx_s = disp_r;
   end

   // Pending register, displayed byte and ready flag.
   always_ff @(posedge clock) begin
      if (reset) begin
         pend_r        <= 8'h00;
         disp_r        <= 8'h00;
         value_ready_r <= 1'b1;
      end else begin
         disp_r <= disp_nx_s;
         if (commit_s) begin
            value_ready_r <= 1'b1;
         end else if (hs_s) begin
            pend_r        <= val_bus.value_in;
            value_ready_r <= 1'b0;
         end else begin
            value_ready_r <= value_ready_r;
         end
      end
   end

   // Segment pattern for the state being entered, so outputs track the state register.
   always_comb begin
      seg_nx_s = SEG_OFF;
      case (state_nx_s)
         SHOW_LO: begin
            if (blank_in) seg_nx_s = SEG_OFF;
            else          seg_nx_s = ~enc7(disp_nx_s[3:0]);
         end
         SHOW_HI: begin
            if (blank_in) begin
               seg_nx_s = SEG_OFF;
`ifdef LEADING_ZERO_BLANK_EN
            end else if (disp_nx_s[7:4] == 4'h0) begin
               seg_nx_s = SEG_OFF;
`endif
            end else begin
               seg_nx_s = ~enc7(disp_nx_s[7:4]);
            end
         end
         default: seg_nx_s = SEG_OFF;
      endcase
   end

   // Registered display outputs; segsel only moves on entry to a blank state.
   always_ff @(posedge clock) begin
      if (reset) begin
         segments_n_r <= SEG_OFF;
         segsel_r     <= 1'b0;
         frame_done_r <= 1'b0;
      end else begin
         segments_n_r <= seg_nx_s;
         segsel_r     <= (state_nx_s == BLANK_TO_HI) || (state_nx_s == SHOW_HI);
         frame_done_r <= last_s && (state_r == BLANK_TO_LO);
      end
   end

   assign segments_n          = segments_n_r;
   assign segsel              = segsel_r;
   assign frame_done          = frame_done_r;
   assign val_bus.value_ready = value_ready_r;

endmodule
